// File: rtl/pwm_gen_pkg.sv
// Shared defaults and helpers for the multi-channel PWM generator.
// Imported by the channel and top-level modules.
package pwm_gen_pkg;

  localparam int CNT_W_DFLT  = 32;
  localparam int PERIOD_DFLT = 249;
  localparam int DUTY_DFLT   = 125;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active config, period counter,
// registered output and wrap strobe.
module pwm_channel
  import pwm_gen_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DFLT,
  parameter int DEF_PERIOD = PERIOD_DFLT,
  parameter int DEF_DUTY   = DUTY_DFLT
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             pwm,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] RST_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] RST_D = CNT_W'(DEF_DUTY);

  logic [CNT_W-1:0] period_s;
  logic [CNT_W-1:0] duty_s;
  logic [CNT_W-1:0] period_a;
  logic [CNT_W-1:0] duty_a;
  logic [CNT_W-1:0] cnt;

  // Active config reloads only from the pre-edge shadow, so a
  // write landing on a boundary takes effect one period later.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      period_s <= RST_P;
      duty_s   <= RST_D;
      period_a <= RST_P;
      duty_a   <= RST_D;
      cnt      <= '0;
      pwm      <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      if (wr) begin
        period_s <= cfg_period;
        duty_s   <= cfg_duty;
      end
      unique case (1'b1)
        !en: begin
          cnt      <= '0;
          pwm      <= 1'b0;
          wrap     <= 1'b0;
          period_a <= period_s;
          duty_a   <= duty_s;
        end
        en && sync: begin
          cnt      <= '0;
          pwm      <= (duty_a != '0);
          wrap     <= 1'b0;
          period_a <= period_s;
          duty_a   <= duty_s;
        end
        default: begin
          pwm <= (cnt < duty_a);
          if (cnt == period_a) begin
            cnt      <= '0;
            wrap     <= 1'b1;
            period_a <= period_s;
            duty_a   <= duty_s;
          end else begin
            cnt  <= cnt + 1'b1;
            wrap <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_ch_pwm_gen.sv
// N-channel PWM generator: config write decode and sync fan-out
// around an array of pwm_channel instances.
module multi_ch_pwm_gen
  import pwm_gen_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int CH_NUM     = 4,
  parameter int CNT_W      = CNT_W_DFLT,
  parameter int DEF_PERIOD = (CLK_HZ == 50_000_000) ?
                             PERIOD_DFLT : (CLK_HZ / 200_000) - 1,
  parameter int DEF_DUTY   = (CLK_HZ == 50_000_000) ?
                             DUTY_DFLT : (DEF_PERIOD + 1) / 2,
  localparam int CH_W      = ch_idx_w(CH_NUM)
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_duty,
  output logic [CH_NUM-1:0] pwm_o,
  output logic [CH_NUM-1:0] wrap_o
);

  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CH_NUM);

  // One spare bit so the range check is real for any CH_NUM.
  logic [CH_W:0]     ch_ext;
  logic              in_range;
  logic [CH_NUM-1:0] ch_wr;

  assign ch_ext   = {1'b0, cfg_ch};
  assign in_range = (ch_ext < CH_LIM);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign ch_wr[i] = cfg_we && in_range &&
                      (ch_ext == (CH_W + 1)'(i));

    pwm_channel #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_DUTY   (DEF_DUTY)
    ) u_ch (
      .sysclk     (sysclk),
      .rst        (rst),
      .en         (en[i]),
      .sync       (sync),
      .wr         (ch_wr[i]),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .pwm        (pwm_o[i]),
      .wrap       (wrap_o[i])
    );
  end

endmodule
